// File: rtl/mandelbrot_pixel_engine.sv
// fixed_multiplication: signed fixed-point multiply, result truncated to width bits (wraps).
// Latency: combinational.
// Backpressure: none.
module fixed_multiplication #(
  parameter int width = 32,
  parameter int frac  = 24
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic [width-1:0] product
);
  logic [2*width-1:0] full;

  // Sign-extend both operands so the low 2*width bits of the product are exact.
  assign full    = {{width{a[width-1]}}, a} * {{width{b[width-1]}}, b};
  assign product = width'(full >> frac);
endmodule

// mandelbrot_iter: one step z' = z^2 + c, plus |z|^2 of the incoming z.
// Latency: combinational.
// Backpressure: none.
module mandelbrot_iter #(
  parameter int width = 32,
  parameter int frac  = 24
) (
  input  logic [width-1:0] z_real,
  input  logic [width-1:0] z_imag,
  input  logic [width-1:0] c_real,
  input  logic [width-1:0] c_imag,
  output logic [width-1:0] out_real,
  output logic [width-1:0] out_imag,
  output logic [width-1:0] size_square
);
  logic [width-1:0] rr, ii, ri;

  fixed_multiplication #(.width(width), .frac(frac)) u_rr (.a(z_real), .b(z_real), .product(rr));
  fixed_multiplication #(.width(width), .frac(frac)) u_ii (.a(z_imag), .b(z_imag), .product(ii));
  fixed_multiplication #(.width(width), .frac(frac)) u_ri (.a(z_real), .b(z_imag), .product(ri));

  assign out_real    = rr - ii + c_real;
  assign out_imag    = {ri[width-2:0], 1'b0} + c_imag;
  assign size_square = rr + ii;
endmodule

// mandelbrot_pixel_engine: iterates one pixel at one step per clock until escape or max_iter.
// Latency: iter_count+1 cycles from accept to out_valid; one pixel in flight.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module mandelbrot_pixel_engine #(
  parameter int width      = 32,
  parameter int frac       = 24,
  parameter int iter_width = 8,
  parameter int tag_width  = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [width-1:0]      c_real,
  input  logic [width-1:0]      c_imag,
  input  logic [iter_width-1:0] max_iter,
  input  logic [tag_width-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [iter_width-1:0] iter_count,
  output logic                  escaped,
  output logic [tag_width-1:0]  out_tag
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic [iter_width-1:0] count;
    logic                  escaped;
    logic [tag_width-1:0]  tag;
  } result_t;

  localparam logic signed [width-1:0] escape_lim = width'(64'sd4 << frac);

  state_t state, state_nxt;

  logic [width-1:0]      z_real_q, z_imag_q, c_real_q, c_imag_q;
  logic [iter_width-1:0] max_q, count_q;
  logic [tag_width-1:0]  tag_q;
  result_t               res_q;

  logic [width-1:0] nxt_real, nxt_imag, size_square;
  logic             esc_hit, limit_hit;

  mandelbrot_iter #(.width(width), .frac(frac)) u_iter (
    .z_real      (z_real_q),
    .z_imag      (z_imag_q),
    .c_real      (c_real_q),
    .c_imag      (c_imag_q),
    .out_real    (nxt_real),
    .out_imag    (nxt_imag),
    .size_square (size_square)
  );

  // A negative size can only come from wrap-around, so it counts as escape too.
  assign esc_hit   = ($signed(size_square) > escape_lim) || size_square[width-1];
  assign limit_hit = (count_q == max_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = RUN;
      RUN:  if (esc_hit || limit_hit) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_real_q <= '0;
      z_imag_q <= '0;
      c_real_q <= '0;
      c_imag_q <= '0;
      max_q    <= '0;
      count_q  <= '0;
      tag_q    <= '0;
      res_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            c_real_q <= c_real;
            c_imag_q <= c_imag;
            max_q    <= max_iter;
            tag_q    <= in_tag;
            z_real_q <= '0;
            z_imag_q <= '0;
            count_q  <= '0;
          end
        end
        RUN: begin
          if (esc_hit) begin
            res_q <= '{count: count_q, escaped: 1'b1, tag: tag_q};
          end else if (limit_hit) begin
            res_q <= '{count: max_q, escaped: 1'b0, tag: tag_q};
          end else begin
            z_real_q <= nxt_real;
            z_imag_q <= nxt_imag;
            count_q  <= count_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign iter_count = res_q.count;
  assign escaped    = res_q.escaped;
  assign out_tag    = res_q.tag;
endmodule

// File: tb/tb_mandelbrot_pixel_engine.sv
// Bench for mandelbrot_pixel_engine: escape-time model plus directed pixels with literal results.
module tb_mandelbrot_pixel_engine;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] c_real = '0;
  logic [31:0] c_imag = '0;
  logic [7:0]  max_iter = '0;
  logic [19:0] in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  iter_count;
  logic        escaped;
  logic [19:0] out_tag;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int          cnt;
    bit          esc;
    logic [19:0] tag;
    int          acc;
  } exp_t;
  exp_t q[$];

  mandelbrot_pixel_engine dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .c_real     (c_real),
    .c_imag     (c_imag),
    .max_iter   (max_iter),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .iter_count (iter_count),
    .escaped    (escaped),
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Q8.24 multiply with truncation, wrapped to 32 bits.
  function automatic int mul(input int a, input int b);
    longint p;
    p = longint'(a) * longint'(b);
    return int'(p >>> 24);
  endfunction

  // Escape-time algorithm: count of steps taken before |z|^2 > 4 (or wraps negative).
  function automatic void mb(input int cr, input int ci, input int mx, output int cnt, output bit esc);
    int zr, zi, rr, ii, sz, nr, ni;
    zr = 0; zi = 0; cnt = mx; esc = 1'b0;
    for (int n = 0; n <= mx; n++) begin
      rr = mul(zr, zr);
      ii = mul(zi, zi);
      sz = rr + ii;
      if (sz > 32'sh0400_0000 || sz < 0) begin
        cnt = n; esc = 1'b1;
        return;
      end
      nr = rr - ii + cr;
      ni = 2 * mul(zr, zi) + ci;
      zr = nr; zi = ni;
    end
  endfunction

  // Cycle-level monitor: in_ready, out_valid timing and result contents follow from the model queue.
  always @(negedge clk) begin
    int  c;
    bit  e;
    exp_t x;
    bit  exp_v;
    if (!rst_n) begin
      q.delete();
    end else begin
      chk("mon_in_ready", in_ready, q.size() == 0);
      exp_v = (q.size() > 0) && (cyc >= q[0].acc + q[0].cnt + 1);
      chk("mon_out_valid", out_valid, exp_v);
      if (out_valid && q.size() > 0) begin
        chk("mon_iter_count", iter_count, q[0].cnt);
        chk("mon_escaped", escaped, q[0].esc);
        chk("mon_out_tag", out_tag, q[0].tag);
        if (out_ready) void'(q.pop_front());
      end
      if (in_valid && in_ready) begin
        mb(c_real, c_imag, int'(max_iter), c, e);
        x.cnt = c; x.esc = e; x.tag = in_tag; x.acc = cyc + 1;
        q.push_back(x);
      end
    end
  end

  int acc_cyc;

  task automatic send(input logic [31:0] cr, input logic [31:0] ci, input logic [7:0] mx, input logic [19:0] tg);
    int n;
    c_real = cr; c_imag = ci; max_iter = mx; in_tag = tg; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    acc_cyc = cyc + 1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    c_real = 32'hDEAD_BEEF; c_imag = 32'h1234_5678; max_iter = 8'hFF; in_tag = '1;
  endtask

  task automatic wait_result(input string name, input int cnt, input int esc, input logic [19:0] tg);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid"}, out_valid, 1);
    if (cnt >= 0) begin
      chk({name, "_latency"}, cyc - acc_cyc, cnt + 1);
      chk({name, "_count"}, iter_count, cnt);
      chk({name, "_escaped"}, escaped, esc);
      chk({name, "_tag"}, out_tag, tg);
    end
  endtask

  task automatic run_pixel(input string name, input logic [31:0] cr, input logic [31:0] ci,
                           input logic [7:0] mx, input logic [19:0] tg, input int cnt, input int esc);
    send(cr, ci, mx, tg);
    wait_result(name, cnt, esc, tg);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    bit e;

    // Pin the model with hand-worked orbits.
    mb(32'h0300_0000, 0, 16, c, e); chk("model_c3", c, 1);  chk("model_c3_esc", e, 1);
    mb(32'h0100_0000, 0, 16, c, e); chk("model_c1", c, 3);  chk("model_c1_esc", e, 1);
    mb(32'hFE00_0000, 0, 16, c, e); chk("model_cm2", c, 16); chk("model_cm2_esc", e, 0);
    mb(0, 0, 16, c, e);             chk("model_c0", c, 16); chk("model_c0_esc", e, 0);

    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_iter_count", iter_count, 0);
    chk("rst_escaped", escaped, 0);
    chk("rst_out_tag", out_tag, 0);
    #21 rst_n = 1'b1;
    @(posedge clk); #1;

    run_pixel("origin",  32'h0000_0000, 32'h0, 8'd16, 20'hABCDE, 16, 0);
    run_pixel("c3",      32'h0300_0000, 32'h0, 8'd16, 20'h00011, 1, 1);
    run_pixel("c1",      32'h0100_0000, 32'h0, 8'd16, 20'h00022, 3, 1);
    run_pixel("cm2",     32'hFE00_0000, 32'h0, 8'd16, 20'h00033, 16, 0);
    run_pixel("max0",    32'h0300_0000, 32'h0, 8'd0,  20'h00044, 0, 0);
    run_pixel("max1",    32'h0300_0000, 32'h0, 8'd1,  20'h00055, 1, 1);
    run_pixel("cm1",     32'hFF00_0000, 32'h0, 8'd50, 20'h00066, 50, 0);
    run_pixel("ci1",     32'h0, 32'h0100_0000, 8'd40, 20'h00077, -1, 0);
    run_pixel("c_quart", 32'h0040_0000, 32'h0080_0000, 8'd60, 20'h00088, -1, 0);
    run_pixel("c_half",  32'h0080_0000, 32'h0080_0000, 8'd60, 20'h00099, -1, 0);
    run_pixel("c_neg",   32'hFF40_0000, 32'hFF00_0000, 8'd255, 20'h000AA, -1, 0);

    // Backpressure: hold the result while a new pixel is offered.
    out_ready = 1'b0;
    send(32'h0300_0000, 32'h0, 8'd16, 20'h00005);
    wait_result("bp_a", 1, 1, 20'h00005);
    @(posedge clk); #1;
    c_real = 32'h0100_0000; c_imag = 32'h0; max_iter = 8'd16; in_tag = 20'h00006; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_count", iter_count, 1);
      chk("bp_hold_escaped", escaped, 1);
      chk("bp_hold_tag", out_tag, 20'h00005);
      chk("bp_hold_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_release_in_ready", in_ready, 1);
    acc_cyc = cyc + 1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result("bp_b", 3, 1, 20'h00006);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a long run.
    send(32'h0, 32'h0, 8'd200, 20'h000BB);
    repeat (50) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_iter_count", iter_count, 0);
    chk("arst_escaped", escaped, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_tag", out_tag, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_pixel("after_rst", 32'h0300_0000, 32'h0, 8'd16, 20'h000CC, 1, 1);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t required=finish", $time);
    $fatal(1, "timeout");
  end
endmodule
